// File: rtl/jleugeri_demon_baby.sv
// jleugeri_demon_baby
//   Virtual-pet game core. Three 4-bit needs (hunger, boredom, tiredness)
//   grow on a slow prescaled game tick. Button presses relieve them. A small
//   mood FSM (AWAKE / ASLEEP / RAGING) and a saturating age counter are
//   reported on the outputs.
//
// Ports
//   clk      system clock
//   rst_n    synchronous reset, active HIGH (asserted when 1)
//   ui_in    [0]=feed [1]=play [2]=sleep buttons, [4:3]=need select, [7:5] unused
//   uo_out   [3:0]=selected need, [5:4]=state, [6]=tick pulse, [7]=rage flag
//   uio_in   unused
//   uio_out  age in ticks, saturating at 255
//   uio_oe   constant 8'hFF
//   ena      ignored
`timescale 1ns/1ps
module jleugeri_demon_baby #(
    parameter int MAX_COUNT = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    typedef enum logic [1:0] {
        AWAKE  = 2'd0,
        ASLEEP = 2'd1,
        RAGING = 2'd2
    } state_t;

    localparam int              CW   = $clog2(MAX_COUNT);
    localparam logic [CW-1:0]   LAST = CW'(MAX_COUNT - 1);

    logic [CW-1:0] count;
    logic [2:0]    btn_prev;
    logic [3:0]    hunger, boredom, tiredness;
    logic [7:0]    age;
    state_t        state, state_next;

    logic          tick;
    logic [2:0]    press;
    logic          asleep, feed_ok, play_ok;
    logic signed [6:0] hunger_sum, boredom_sum, tiredness_sum;
    logic [3:0]    max_need, sel_need;

    // Needs are summed at a wider signed width so both directions can clamp
    // instead of wrapping.
    function automatic logic [3:0] clamp(input logic signed [6:0] v);
        if (v < 0)
            return 4'd0;
        else if (v > 15)
            return 4'd15;
        else
            return v[3:0];
    endfunction

    assign tick    = (count == LAST);
    // A press is a rising edge against last cycle's button level.
    assign press   = ui_in[2:0] & ~btn_prev;
    assign asleep  = (state == ASLEEP);
    assign feed_ok = press[0] && !asleep;
    assign play_ok = press[1] && !asleep;

    assign hunger_sum    = $signed({3'b000, hunger})
                         + (tick    ? 7'sd1 : 7'sd0)
                         - (feed_ok ? 7'sd4 : 7'sd0);
    assign boredom_sum   = $signed({3'b000, boredom})
                         + (tick    ? 7'sd1 : 7'sd0)
                         - (play_ok ? 7'sd4 : 7'sd0);
    assign tiredness_sum = $signed({3'b000, tiredness})
                         + (tick    ? (asleep ? -7'sd2 : 7'sd1) : 7'sd0)
                         + (play_ok ? 7'sd2 : 7'sd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count     <= '0;
            btn_prev  <= '0;
            hunger    <= '0;
            boredom   <= '0;
            tiredness <= '0;
            age       <= '0;
            state     <= AWAKE;
        end else begin
            count     <= tick ? '0 : count + 1'b1;
            btn_prev  <= ui_in[2:0];
            hunger    <= clamp(hunger_sum);
            boredom   <= clamp(boredom_sum);
            tiredness <= clamp(tiredness_sum);
            if (tick && age != 8'hFF)
                age <= age + 8'd1;
            state     <= state_next;
        end
    end

    // Mood decisions look at the registered needs, so they lag a need change
    // by one cycle.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        case (state)
            ASLEEP: begin
                if (hunger == 4'd15)
                    state_next = RAGING;
                else if (press[2])
                    state_next = AWAKE;
                else if (tiredness == 4'd0)
                    state_next = AWAKE;
            end
            RAGING: begin
                if (hunger <= 4'd11 && boredom <= 4'd11 && tiredness <= 4'd11)
                    state_next = AWAKE;
            end
            default: begin
                // AWAKE, and the unused encoding behaves as AWAKE.
                state_next = AWAKE;
                if (hunger == 4'd15 || boredom == 4'd15 || tiredness == 4'd15)
                    state_next = RAGING;
                else if (press[2])
                    state_next = ASLEEP;
            end
        endcase
    end

    always_comb begin
        max_need = hunger;
        if (boredom > max_need)
            max_need = boredom;
        if (tiredness > max_need)
            max_need = tiredness;

        case (ui_in[4:3])
            2'd0:    sel_need = hunger;
            2'd1:    sel_need = boredom;
            2'd2:    sel_need = tiredness;
            default: sel_need = max_need;
        endcase
    end

    assign uo_out  = {(state == RAGING), tick, state, sel_need};
    assign uio_out = age;
    assign uio_oe  = 8'hFF;

    logic unused;
    assign unused = &{1'b0, ena, uio_in, ui_in[7:5]};

endmodule

// File: tb/tb_jleugeri_demon_baby.sv
// tb_jleugeri_demon_baby
//   Directed bench for the demon-baby game core with a 1000-cycle tick.
//   Inputs change 1 ns after a rising edge; outputs are read there too.
`timescale 1ns/1ps
module tb_jleugeri_demon_baby;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jleugeri_demon_baby #(.MAX_COUNT(1000)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Select a need on ui_in[4:3] and check the displayed value.
    task automatic check_need(input string tag, input logic [1:0] sel,
                              input logic [3:0] expected);
        ui_in[4:3] = sel;
        #1;
        check(tag, {4'h0, uo_out[3:0]}, {4'h0, expected});
    endtask

    task automatic check_state(input string tag, input logic [1:0] expected);
        check(tag, {6'h0, uo_out[5:4]}, {6'h0, expected});
    endtask

    // Step until the tick pulse is seen (bounded), then one more cycle so
    // the tick's effect on the needs is visible.
    task automatic wait_tick(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 1100 && !seen; i++) begin
            step(1);
            if (uo_out[6]) seen = 1'b1;
        end
        check(tag, {7'h0, seen}, 8'h01);
        step(1);
    endtask

    initial begin
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        rst_n  = 1'b1;

        // Reset state, held while rst_n stays high even with buttons active.
        step(5);
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hFF);
        ui_in[0] = 1'b1;
        ui_in[1] = 1'b1;
        step(3);
        check("reset_hold_uo", uo_out, 8'h00);
        ui_in = 8'h00;
        step(1);

        // First tick exactly 1000 cycles after release, one cycle wide.
        rst_n = 1'b0;
        step(998);
        check("pre_tick", uo_out, 8'h00);
        step(1);
        check("tick_pulse", uo_out, 8'h40);
        step(1);
        check("post_tick", uo_out, 8'h01);
        check("age_1", uio_out, 8'h01);

        // Fourteen more ticks: all needs 15, rage one cycle later.
        for (int t = 0; t < 14; t++) wait_tick("idle_tick");
        check_need("hunger_15", 2'd0, 4'd15);
        check_need("boredom_15", 2'd1, 4'd15);
        check_need("tired_15", 2'd2, 4'd15);
        check_state("rage_pending", 2'd0);
        ui_in[4:3] = 2'd0;
        step(1);
        check("rage_uo", uo_out, 8'hAF);
        check("age_15", uio_out, 8'h0F);

        // Feed then play while raging.
        ui_in[0] = 1'b1;
        step(1);
        ui_in[0] = 1'b0;
        ui_in[1] = 1'b1;
        step(1);
        ui_in[1] = 1'b0;
        check_need("rage_feed", 2'd0, 4'd11);
        check_need("rage_play", 2'd1, 4'd11);
        check_need("rage_tired_clamp", 2'd2, 4'd15);
        check_need("rage_max", 2'd3, 4'd15);
        check("still_raging", {4'h0, uo_out[7:4]}, 8'h0A);

        // Reset out of RAGING.
        rst_n = 1'b1;
        step(1);
        check("rage_reset_uo", uo_out, 8'h00);
        check("rage_reset_age", uio_out, 8'h00);
        rst_n = 1'b0;

        // Feed clamps at 0; holding feed acts once.
        wait_tick("s2_tick1");
        wait_tick("s2_tick2");
        check_need("hunger_2", 2'd0, 4'd2);
        ui_in[0] = 1'b1;
        step(1);
        check_need("feed_clamp", 2'd0, 4'd0);
        wait_tick("hold_tick");
        check_need("feed_hold", 2'd0, 4'd1);
        check_need("boredom_3", 2'd1, 4'd3);
        check_need("tired_3", 2'd2, 4'd3);
        ui_in[0] = 1'b0;
        step(1);

        // Play: boredom clamps to 0, tiredness +2.
        ui_in[1] = 1'b1;
        step(1);
        ui_in[1] = 1'b0;
        check_need("play_boredom", 2'd1, 4'd0);
        check_need("play_tired", 2'd2, 4'd5);

        // Sleep, feed ignored, tiredness drains to 0 then wakes.
        ui_in[2] = 1'b1;
        step(1);
        ui_in[2] = 1'b0;
        check_state("asleep", 2'd1);
        step(1);
        check_state("asleep_hold", 2'd1);
        ui_in[0] = 1'b1;
        step(1);
        ui_in[0] = 1'b0;
        check_need("asleep_feed", 2'd0, 4'd1);
        wait_tick("sleep_tick1");
        check_need("sleep_tired_3", 2'd2, 4'd3);
        wait_tick("sleep_tick2");
        check_need("sleep_tired_1", 2'd2, 4'd1);
        wait_tick("sleep_tick3");
        check_need("sleep_tired_0", 2'd2, 4'd0);
        check_need("sleep_hunger_4", 2'd0, 4'd4);
        check_state("asleep_at_0", 2'd1);
        step(1);
        check_state("woke", 2'd0);

        // Mid-game reset at age 7.
        wait_tick("age7_tick");
        check("age_7", uio_out, 8'h07);
        check_need("hunger_5", 2'd0, 4'd5);
        ui_in[4:3] = 2'd3;
        rst_n = 1'b1;
        step(1);
        check("mid_reset_uo", uo_out, 8'h00);
        check("mid_reset_age", uio_out, 8'h00);
        rst_n = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
